// File: rtl/pi_client_endpoint.sv
// Pi-tree NoC client endpoint: PE <-> level-0 switch, with
// injection/ejection FIFOs, packet counters and sticky error flags.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pe_tx_d/a/f/v/rdy   PE send side (valid/ready)
//   pe_rx_d/f/v/rdy     PE receive side (valid/ready)
//   noc_o, noc_o_v/bp   packet {f,addr,data} to switch (valid/backpressure)
//   noc_i, noc_i_v/bp   packet from switch (valid/backpressure)
//   tx_cnt, rx_cnt      wrapping transfer counters on the NoC side
//   err_self            sticky: PE sent to its own address
//   err_route           sticky: ejected packet not addressed to POSX
module pi_client_endpoint #(
   parameter int N         = 4,
   parameter int A_W       = $clog2(N) + 1,
   parameter int D_W       = 32,
   parameter int POSX      = 0,
   parameter int INJ_DEPTH = 4,
   parameter int EJ_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [D_W-1:0]       pe_tx_d,
   input  logic [A_W-1:0]       pe_tx_a,
   input  logic                 pe_tx_f,
   input  logic                 pe_tx_v,
   output logic                 pe_tx_rdy,
   output logic [D_W-1:0]       pe_rx_d,
   output logic                 pe_rx_f,
   output logic                 pe_rx_v,
   input  logic                 pe_rx_rdy,
   output logic [A_W+D_W:0]     noc_o,
   output logic                 noc_o_v,
   input  logic                 noc_o_bp,
   input  logic [A_W+D_W:0]     noc_i,
   input  logic                 noc_i_v,
   output logic                 noc_i_bp,
   output logic [31:0]          tx_cnt,
   output logic [31:0]          rx_cnt,
   output logic                 err_self,
   output logic                 err_route
);

   localparam int P_W  = A_W + D_W + 1;
   localparam int IP_W = $clog2(INJ_DEPTH);
   localparam int EP_W = $clog2(EJ_DEPTH);

   localparam logic [IP_W:0]  INJ_FULL = (IP_W+1)'(INJ_DEPTH);
   localparam logic [EP_W:0]  EJ_FULL  = (EP_W+1)'(EJ_DEPTH);
   localparam logic [A_W-1:0] SELF     = A_W'(POSX);

   logic [P_W-1:0] inj_mem [INJ_DEPTH];
   logic [IP_W-1:0] inj_wp;
   logic [IP_W-1:0] inj_rp;
   logic [IP_W:0]   inj_cnt;

   // The address is not needed after ejection, so only {f, data} is stored.
   logic [D_W:0]    ej_mem [EJ_DEPTH];
   logic [EP_W-1:0] ej_wp;
   logic [EP_W-1:0] ej_rp;
   logic [EP_W:0]   ej_cnt;

   logic           tx_fire;
   logic           tx_self;
   logic           inj_push;
   logic           inj_pop;
   logic           ej_push;
   logic           ej_pop;
   logic [A_W-1:0] rx_a;
   logic [D_W:0]   ej_head;

   // Ready/backpressure depend only on registered counts, so there is
   // no combinational path from the opposite side's handshake.
   assign pe_tx_rdy = (inj_cnt != INJ_FULL);
   assign tx_fire   = pe_tx_v & pe_tx_rdy;
   assign tx_self   = (pe_tx_a == SELF);
   assign inj_push  = tx_fire & ~tx_self;

   assign noc_o_v = (inj_cnt != '0);
   assign inj_pop = noc_o_v & ~noc_o_bp;
   assign noc_o   = noc_o_v ? inj_mem[inj_rp] : '0;

   assign noc_i_bp = (ej_cnt == EJ_FULL);
   assign ej_push  = noc_i_v & ~noc_i_bp;
   assign rx_a     = noc_i[A_W+D_W-1:D_W];

   assign pe_rx_v = (ej_cnt != '0);
   assign ej_pop  = pe_rx_v & pe_rx_rdy;
   assign ej_head = pe_rx_v ? ej_mem[ej_rp] : '0;
   assign pe_rx_f = ej_head[D_W];
   assign pe_rx_d = ej_head[D_W-1:0];

   always_ff @(posedge clk) begin
      if (inj_push)
         inj_mem[inj_wp] <= {pe_tx_f, pe_tx_a, pe_tx_d};
      if (ej_push)
         ej_mem[ej_wp] <= {noc_i[P_W-1], noc_i[D_W-1:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inj_wp    <= '0;
         inj_rp    <= '0;
         inj_cnt   <= '0;
         ej_wp     <= '0;
         ej_rp     <= '0;
         ej_cnt    <= '0;
         tx_cnt    <= '0;
         rx_cnt    <= '0;
         err_self  <= 1'b0;
         err_route <= 1'b0;
      end else begin
         if (inj_push)
            inj_wp <= inj_wp + IP_W'(1);
         if (inj_pop)
            inj_rp <= inj_rp + IP_W'(1);
         inj_cnt <= inj_cnt + (IP_W+1)'(inj_push)
                            - (IP_W+1)'(inj_pop);

         if (ej_push)
            ej_wp <= ej_wp + EP_W'(1);
         if (ej_pop)
            ej_rp <= ej_rp + EP_W'(1);
         ej_cnt <= ej_cnt + (EP_W+1)'(ej_push)
                          - (EP_W+1)'(ej_pop);

         if (inj_pop)
            tx_cnt <= tx_cnt + 32'd1;
         if (ej_push)
            rx_cnt <= rx_cnt + 32'd1;

         // Self-addressed sends are swallowed here and only flagged.
         if (tx_fire & tx_self)
            err_self <= 1'b1;
         if (ej_push & (rx_a != SELF))
            err_route <= 1'b1;
      end
   end

endmodule
